// File: rtl/mac_tile_scheduler_if.sv
// Host-side command/response channel of the tile scheduler.
//   cmd_*  : one job per accepted command (valid/ready handshake)
//   rsp_*  : one status response per job (valid/ready handshake)
// master = command queue / response consumer, slave = scheduler.
interface mac_tile_scheduler_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int TILE_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [TILE_WIDTH-1:0] cmd_tiles;
    logic [1:0]            cmd_mode;
    logic                  cmd_vsq;
    logic [7:0]            cmd_scale;
    logic [7:0]            cmd_bias;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [TILE_WIDTH-1:0] rsp_tiles;

    modport master (
        output cmd_valid, cmd_base, cmd_tiles, cmd_mode, cmd_vsq, cmd_scale, cmd_bias, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_tiles
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_tiles, cmd_mode, cmd_vsq, cmd_scale, cmd_bias, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_tiles
    );
endinterface

// File: rtl/mac_tile_scheduler.sv
// Job sequencer for the matrix accelerator. A command names a base address
// and a tile count; each tile streams CALC_COUNT operand reads, then waits
// for the accelerator's done pulse (bounded by TIMEOUT cycles). The job ends
// with one status response on the host channel.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   host (slave)         command in / response out
//   opnd_rd_en/opnd_addr operand SRAM read port (data one cycle later)
//   valid_mac/valid_ppu  accelerator beat valid / PPU enable
//   is_int8_mode, is_int4_mode, is_vsq, scale, bias  job configuration
//   acc_done             accelerator tile-done pulse
//   busy                 scheduler not idle
module mac_tile_scheduler #(
    parameter int CALC_COUNT     = 32,
    parameter int CALC_BIT_WIDTH = 5,
    parameter int ADDR_WIDTH     = 12,
    parameter int TILE_WIDTH     = 8,
    parameter int TIMEOUT        = 1024,
    parameter int TIMEOUT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mac_tile_scheduler_if.slave   host,
    output logic                  opnd_rd_en,
    output logic [ADDR_WIDTH-1:0] opnd_addr,
    output logic                  valid_mac,
    output logic                  valid_ppu,
    output logic                  is_int8_mode,
    output logic                  is_int4_mode,
    output logic                  is_vsq,
    output logic [7:0]            scale,
    output logic [7:0]            bias,
    input  logic                  acc_done,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT, RESP} state_t;

    state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]      base;
    logic [TILE_WIDTH-1:0]      tiles;
    logic [TILE_WIDTH-1:0]      tile_cnt;
    logic [CALC_BIT_WIDTH-1:0]  beat;
    logic [TIMEOUT_WIDTH-1:0]   to_cnt;
    logic                       err;

    // Accept looks at the state directly rather than cmd_ready to keep the
    // handshake free of output feedback.
    logic accept, last_beat, last_tile, expired;
    assign accept    = host.cmd_valid && (state == IDLE);
    assign last_beat = (beat == CALC_BIT_WIDTH'(CALC_COUNT - 1));
    assign last_tile = ((tile_cnt + TILE_WIDTH'(1)) == tiles);
    assign expired   = (to_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));

    // CALC_COUNT is a power of two, so tile_cnt*CALC_COUNT + beat is just
    // the concatenation; the sum wraps modulo the SRAM size.
    logic [TILE_WIDTH+CALC_BIT_WIDTH-1:0] offset;
    assign offset = {tile_cnt, beat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        host.cmd_ready = 1'b0;
        host.rsp_valid = 1'b0;
        busy           = 1'b1;
        opnd_rd_en     = 1'b0;
        valid_ppu      = 1'b0;
        opnd_addr      = '0;
        case (state)
            IDLE: begin
                host.cmd_ready = 1'b1;
                busy           = 1'b0;
                if (accept) begin
                    if (host.cmd_mode == 2'b11 || host.cmd_tiles == '0) state_nxt = RESP;
                    else                                                state_nxt = RUN;
                end
            end
            RUN: begin
                opnd_rd_en = 1'b1;
                valid_ppu  = 1'b1;
                opnd_addr  = base + ADDR_WIDTH'(offset);
                if (last_beat) state_nxt = WAIT;
            end
            WAIT: begin
                valid_ppu = 1'b1;
                // done beats a coincident timeout
                if (acc_done)     state_nxt = last_tile ? RESP : RUN;
                else if (expired) state_nxt = RESP;
            end
            RESP: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base         <= '0;
            tiles        <= '0;
            tile_cnt     <= '0;
            beat         <= '0;
            to_cnt       <= '0;
            err          <= 1'b0;
            valid_mac    <= 1'b0;
            is_int8_mode <= 1'b0;
            is_int4_mode <= 1'b0;
            is_vsq       <= 1'b0;
            scale        <= '0;
            bias         <= '0;
        end else begin
            // read data lands one cycle after the strobe
            valid_mac <= opnd_rd_en;
            case (state)
                IDLE: if (accept) begin
                    base         <= host.cmd_base;
                    tiles        <= host.cmd_tiles;
                    is_int8_mode <= (host.cmd_mode == 2'b01);
                    is_int4_mode <= (host.cmd_mode == 2'b10);
                    is_vsq       <= host.cmd_vsq;
                    scale        <= host.cmd_scale;
                    bias         <= host.cmd_bias;
                    tile_cnt     <= '0;
                    beat         <= '0;
                    err          <= (host.cmd_mode == 2'b11);
                end
                RUN: begin
                    beat <= beat + CALC_BIT_WIDTH'(1);
                    if (last_beat) to_cnt <= '0;
                end
                WAIT: begin
                    to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
                    if (acc_done) begin
                        tile_cnt <= tile_cnt + TILE_WIDTH'(1);
                        beat     <= '0;
                    end else if (expired) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // tile_cnt already holds the number of completed tiles when RESP is entered
    assign host.rsp_err   = err;
    assign host.rsp_tiles = tile_cnt;
endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Scoreboard bench for mac_tile_scheduler: expected read addresses and
// responses are queued when a command is issued and popped by the monitor
// as the DUT produces reads and response handshakes.
module tb_mac_tile_scheduler;
    localparam int AW = 12;
    localparam int TW = 8;
    localparam int CC = 32;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          acc_done = 1'b0;
    logic          opnd_rd_en, valid_mac, valid_ppu, is_int8_mode, is_int4_mode, is_vsq, busy;
    logic [AW-1:0] opnd_addr;
    logic [7:0]    scale, bias;

    int            vectors = 0;
    int            errors = 0;
    logic [AW-1:0] addr_q[$];
    logic [TW:0]   rsp_q[$];   // {err, tiles}
    logic          prev_rd = 1'b0;
    logic [AW-1:0] ea;
    logic [TW:0]   er;

    mac_tile_scheduler_if #(.ADDR_WIDTH(AW), .TILE_WIDTH(TW)) h();

    mac_tile_scheduler #(
        .CALC_COUNT(CC), .CALC_BIT_WIDTH(5), .ADDR_WIDTH(AW), .TILE_WIDTH(TW),
        .TIMEOUT(TO), .TIMEOUT_WIDTH(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host(h),
        .opnd_rd_en(opnd_rd_en), .opnd_addr(opnd_addr),
        .valid_mac(valid_mac), .valid_ppu(valid_ppu),
        .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq),
        .scale(scale), .bias(bias), .acc_done(acc_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: read-address scoreboard, valid_mac lag, response scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
        end else begin
            vectors++;
            if (valid_mac !== prev_rd) begin
                errors++;
                $display("FAIL valid_mac_lag: got %b want %b at %0t", valid_mac, prev_rd, $time);
            end
            prev_rd = opnd_rd_en;
            if (opnd_rd_en === 1'b1) begin
                vectors++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL opnd_read: got read of %h want no read at %0t", opnd_addr, $time);
                end else begin
                    ea = addr_q.pop_front();
                    if (opnd_addr !== ea) begin
                        errors++;
                        $display("FAIL opnd_addr: got %h want %h at %0t", opnd_addr, ea, $time);
                    end
                end
            end
            if (h.rsp_valid === 1'b1 && h.rsp_ready === 1'b1) begin
                vectors++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp: got unexpected response at %0t", $time);
                end else begin
                    er = rsp_q.pop_front();
                    if ({h.rsp_err, h.rsp_tiles} !== er) begin
                        errors++;
                        $display("FAIL rsp: got err=%b tiles=%0d want err=%b tiles=%0d",
                                 h.rsp_err, h.rsp_tiles, er[TW], er[TW-1:0]);
                    end
                end
            end
        end
    end

    task automatic push_addrs(input logic [AW-1:0] base, input int ntiles);
        int a;
        for (int t = 0; t < ntiles; t++)
            for (int b = 0; b < CC; b++) begin
                a = int'(base) + t * CC + b;
                addr_q.push_back(a[AW-1:0]);
            end
    endtask

    // Presents a command and returns just after the accepting edge.
    task automatic send_cmd(input logic [AW-1:0] base, input logic [TW-1:0] tiles,
                            input logic [1:0] mode, input logic vsq,
                            input logic [7:0] sc, input logic [7:0] bi);
        int n = 0;
        @(posedge clk); #1;
        h.cmd_base = base; h.cmd_tiles = tiles; h.cmd_mode = mode;
        h.cmd_vsq = vsq; h.cmd_scale = sc; h.cmd_bias = bi; h.cmd_valid = 1'b1;
        @(negedge clk);
        while (h.cmd_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (h.cmd_ready !== 1'b1) begin
            vectors++; errors++;
            $display("FAIL cmd_accept: got cmd_ready=%b want 1 within bound", h.cmd_ready);
        end
        @(posedge clk); #1 h.cmd_valid = 1'b0;
    endtask

    // Counts one contiguous burst of reads; returns at the first WAIT cycle.
    task automatic run_burst(output int n);
        int g = 0;
        n = 0;
        @(negedge clk);
        while (opnd_rd_en !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        while (opnd_rd_en === 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    // Called in WAIT cycle 0; acc_done is seen by the DUT in WAIT cycle j.
    task automatic pulse_done(input int j);
        repeat (j) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
    endtask

    // Waits for a response, accepts it, returns in the following IDLE cycle.
    task automatic wait_rsp;
        int n = 0;
        while (h.rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (h.rsp_valid !== 1'b1) begin
            vectors++; errors++;
            $display("FAIL rsp_wait: got rsp_valid=%b want 1 within bound", h.rsp_valid);
        end
        @(posedge clk); #1 h.rsp_ready = 1'b1;
        @(posedge clk); #1 h.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        h.cmd_valid = 1'b0; h.rsp_ready = 1'b0; h.cmd_base = '0; h.cmd_tiles = '0;
        h.cmd_mode = '0; h.cmd_vsq = 1'b0; h.cmd_scale = '0; h.cmd_bias = '0;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({h.cmd_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_ready_busy: got %b%b want 10", h.cmd_ready, busy);
        end
        vectors++;
        if ({opnd_rd_en, valid_mac, valid_ppu, h.rsp_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_valids: got %b%b%b%b want 0000", opnd_rd_en, valid_mac, valid_ppu, h.rsp_valid);
        end
        vectors++;
        if ({is_int8_mode, is_int4_mode, is_vsq, scale, bias} !== 19'b0) begin
            errors++; $display("FAIL reset_config: got %b%b%b %h %h want all 0", is_int8_mode, is_int4_mode, is_vsq, scale, bias);
        end
        vectors++;
        if ({h.rsp_err, h.rsp_tiles, opnd_addr} !== '0) begin
            errors++; $display("FAIL reset_rsp_addr: got err=%b tiles=%0d addr=%h want 0", h.rsp_err, h.rsp_tiles, opnd_addr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_int8;
        int n;
        push_addrs(12'h100, 1);
        rsp_q.push_back({1'b0, 8'd1});
        send_cmd(12'h100, 8'd1, 2'b01, 1'b0, 8'h10, 8'h02);
        vectors++;
        if ({is_int8_mode, is_int4_mode, scale, bias} !== {2'b10, 8'h10, 8'h02}) begin
            errors++; $display("FAIL int8_config: got %b%b %h %h want 10 10 02", is_int8_mode, is_int4_mode, scale, bias);
        end
        vectors++;
        if ({busy, h.cmd_ready, valid_ppu} !== 3'b101) begin
            errors++; $display("FAIL int8_run_flags: got %b%b%b want 101", busy, h.cmd_ready, valid_ppu);
        end
        run_burst(n);
        vectors++;
        if (n != CC) begin errors++; $display("FAIL int8_burst_len: got %0d want %0d", n, CC); end
        vectors++;
        if ({valid_ppu, valid_mac} !== 2'b11) begin
            errors++; $display("FAIL int8_wait0: got ppu=%b mac=%b want 11", valid_ppu, valid_mac);
        end
        pulse_done(5);
        @(negedge clk);
        vectors++;
        if ({h.rsp_valid, valid_ppu} !== 2'b10) begin
            errors++; $display("FAIL int8_resp_state: got rsp_valid=%b ppu=%b want 10", h.rsp_valid, valid_ppu);
        end
        wait_rsp();
        vectors++;
        if ({h.cmd_ready, h.rsp_valid, is_int8_mode, scale} !== {3'b101, 8'h10}) begin
            errors++; $display("FAIL int8_idle: got ready=%b rsp=%b int8=%b scale=%h want 1 0 1 10", h.cmd_ready, h.rsp_valid, is_int8_mode, scale);
        end
    endtask

    task automatic test_int4_wrap;
        int n;
        push_addrs(12'hFF0, 3);
        rsp_q.push_back({1'b0, 8'd3});
        send_cmd(12'hFF0, 8'd3, 2'b10, 1'b1, 8'h33, 8'h44);
        vectors++;
        if ({is_int8_mode, is_int4_mode, is_vsq} !== 3'b011) begin
            errors++; $display("FAIL int4_config: got %b%b%b want 011", is_int8_mode, is_int4_mode, is_vsq);
        end
        for (int t = 0; t < 3; t++) begin
            run_burst(n);
            vectors++;
            if (n != CC) begin errors++; $display("FAIL int4_burst_len tile %0d: got %0d want %0d", t, n, CC); end
            pulse_done(t + 1);
        end
        wait_rsp();
    endtask

    task automatic test_timeout;
        int n;
        push_addrs(12'h020, 2);
        rsp_q.push_back({1'b1, 8'd1});
        send_cmd(12'h020, 8'd2, 2'b00, 1'b0, 8'h01, 8'h01);
        run_burst(n);
        pulse_done(3);
        run_burst(n);
        vectors++;
        if (n != CC) begin errors++; $display("FAIL timeout_burst_len: got %0d want %0d", n, CC); end
        n = 0;
        while (h.rsp_valid !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        vectors++;
        if (n != TO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
        wait_rsp();
    endtask

    task automatic test_done_at_timeout;
        int n;
        push_addrs(12'h7E0, 1);
        rsp_q.push_back({1'b0, 8'd1});
        send_cmd(12'h7E0, 8'd1, 2'b01, 1'b0, 8'h05, 8'h06);
        run_burst(n);
        pulse_done(TO - 1);
        wait_rsp();
    endtask

    task automatic test_illegal;
        rsp_q.push_back({1'b1, 8'd0});
        send_cmd(12'h400, 8'd4, 2'b11, 1'b1, 8'h77, 8'h88);
        vectors++;
        if ({h.rsp_valid, h.rsp_err, h.rsp_tiles, valid_ppu} !== {2'b11, 8'd0, 1'b0}) begin
            errors++; $display("FAIL illegal_resp: got rsp=%b err=%b tiles=%0d ppu=%b want 1 1 0 0", h.rsp_valid, h.rsp_err, h.rsp_tiles, valid_ppu);
        end
        vectors++;
        if ({is_int8_mode, is_int4_mode} !== 2'b00) begin
            errors++; $display("FAIL illegal_mode_flags: got %b%b want 00", is_int8_mode, is_int4_mode);
        end
        repeat (3) @(negedge clk);
        wait_rsp();
    endtask

    task automatic test_backpressure_zero;
        int n;
        rsp_q.push_back({1'b0, 8'd0});
        send_cmd(12'h200, 8'd0, 2'b00, 1'b0, 8'h01, 8'h02);
        push_addrs(12'h040, 1);
        rsp_q.push_back({1'b0, 8'd1});
        h.cmd_base = 12'h040; h.cmd_tiles = 8'd1; h.cmd_mode = 2'b01;
        h.cmd_vsq = 1'b0; h.cmd_scale = 8'h99; h.cmd_bias = 8'h11; h.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({h.rsp_valid, h.cmd_ready, scale} !== {2'b10, 8'h01}) begin
                errors++; $display("FAIL bp_hold cycle %0d: got rsp=%b ready=%b scale=%h want 1 0 01", i, h.rsp_valid, h.cmd_ready, scale);
            end
        end
        @(posedge clk); #1 h.rsp_ready = 1'b1;
        @(posedge clk); #1 h.rsp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({h.cmd_ready, busy, h.rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL bp_idle: got ready=%b busy=%b rsp=%b want 100", h.cmd_ready, busy, h.rsp_valid);
        end
        @(posedge clk); #1 h.cmd_valid = 1'b0;
        vectors++;
        if ({busy, scale} !== {1'b1, 8'h99}) begin
            errors++; $display("FAIL bp_second_accept: got busy=%b scale=%h want 1 99", busy, scale);
        end
        run_burst(n);
        vectors++;
        if (n != CC) begin errors++; $display("FAIL bp_burst_len: got %0d want %0d", n, CC); end
        pulse_done(2);
        wait_rsp();
    endtask

    task automatic test_reset_mid_run;
        int n;
        for (int b = 0; b < 7; b++) addr_q.push_back(12'h300 + 12'(b));
        send_cmd(12'h300, 8'd2, 2'b01, 1'b1, 8'h55, 8'hAA);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({opnd_rd_en, valid_mac, valid_ppu, busy, h.cmd_ready} !== 5'b00001) begin
            errors++; $display("FAIL midrst_flags: got %b%b%b%b%b want 00001", opnd_rd_en, valid_mac, valid_ppu, busy, h.cmd_ready);
        end
        vectors++;
        if ({is_int8_mode, is_vsq, scale, bias, opnd_addr} !== '0) begin
            errors++; $display("FAIL midrst_config: got %b%b %h %h %h want 0", is_int8_mode, is_vsq, scale, bias, opnd_addr);
        end
        vectors++;
        if (addr_q.size() != 0) begin errors++; $display("FAIL midrst_reads: got %0d reads missing want 0", addr_q.size()); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 acc_done = 1'b1;
        @(posedge clk); #1 acc_done = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, h.rsp_valid, h.rsp_tiles} !== 10'b0) begin
            errors++; $display("FAIL stray_done: got busy=%b rsp=%b tiles=%0d want 0 0 0", busy, h.rsp_valid, h.rsp_tiles);
        end
        push_addrs(12'h0A0, 1);
        rsp_q.push_back({1'b0, 8'd1});
        send_cmd(12'h0A0, 8'd1, 2'b00, 1'b0, 8'h00, 8'h00);
        run_burst(n);
        vectors++;
        if (n != CC) begin errors++; $display("FAIL post_reset_burst_len: got %0d want %0d", n, CC); end
        pulse_done(1);
        wait_rsp();
    endtask

    task automatic test_drained;
        vectors++;
        if (addr_q.size() != 0 || rsp_q.size() != 0) begin
            errors++; $display("FAIL drained: got %0d reads %0d rsps outstanding want 0 0", addr_q.size(), rsp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_int8();
        test_int4_wrap();
        test_timeout();
        test_done_at_timeout();
        test_illegal();
        test_backpressure_zero();
        test_reset_mid_run();
        test_drained();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mac_tile_scheduler.md
Name: mac_tile_scheduler

Overview:
Command-driven sequencer that runs the matrix accelerator through a job of one or more tiles. For each tile it fetches CALC_COUNT operand beats from the operand SRAM and drives valid_mac one cycle behind each read. It holds valid_ppu through the tile and waits for the accelerator's done pulse. When the job finishes it returns a status response. It sits between the host command queue and the accelerator and owns all of its mode, scale and bias configuration.

Parameters:
CALC_COUNT, 32, operand beats per tile; must match the accelerator.
CALC_BIT_WIDTH, 5, beat counter width; log2(CALC_COUNT).
ADDR_WIDTH, 12, operand SRAM address width.
TILE_WIDTH, 8, width of the tile count.
TIMEOUT, 1024, maximum number of WAIT cycles per tile before an error.
TIMEOUT_WIDTH, 10, timeout counter width; log2(TIMEOUT).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  scheduler can accept a command
cmd_base  in  ADDR_WIDTH  first operand address
cmd_tiles  in  TILE_WIDTH  number of tiles in the job
cmd_mode  in  2  00 default, 01 int8, 10 int4, 11 illegal
cmd_vsq  in  1  VSQ enable
cmd_scale  in  8  PPU scale
cmd_bias  in  8  PPU bias
opnd_rd_en  out  1  SRAM read strobe; data returns 1 cycle later
opnd_addr  out  ADDR_WIDTH  SRAM read address
valid_mac  out  1  accelerator MAC beat valid
valid_ppu  out  1  accelerator PPU enable
is_int8_mode  out  1  mode to accelerator
is_int4_mode  out  1  mode to accelerator
is_vsq  out  1  VSQ to accelerator
scale  out  8  scale to accelerator
bias  out  8  bias to accelerator
acc_done  in  1  accelerator done pulse
busy  out  1  high whenever state is not IDLE
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_err  out  1  job failed (illegal mode or timeout)
rsp_tiles  out  TILE_WIDTH  number of tiles completed

Behaviour:
- The clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, cmd_ready=1, and every other output 0, including all configuration registers and counters.
- States are IDLE, RUN, WAIT and RESP. cmd_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE, accepting a command:
  - A command is accepted when cmd_valid && cmd_ready.
  - On accept, register base, tiles, mode, vsq, scale and bias.
  - is_int8_mode = mode==01 and is_int4_mode = mode==10, both registered.
  - These configuration outputs stay stable until the next accept.
  - Clear tile_cnt and rsp_err.
- IDLE, next-state selection:
  - mode==11: go to RESP with rsp_err=1, rsp_tiles=0, and issue no reads.
  - cmd_tiles==0: go to RESP with rsp_err=0, rsp_tiles=0.
  - Otherwise go to RUN with beat=0.
- RUN:
  - opnd_rd_en=1 every cycle.
  - opnd_addr = base + tile_cnt*CALC_COUNT + beat, modulo 2^ADDR_WIDTH; wrap-around is legal.
  - beat increments each cycle.
  - After beat CALC_COUNT-1, go to WAIT and clear the timeout counter.
  - Each tile's RUN lasts exactly CALC_COUNT cycles, with no bubbles.
- valid_mac is opnd_rd_en delayed by one register stage. The last beat's valid_mac therefore falls in the first WAIT cycle.
- valid_ppu=1 throughout RUN and WAIT, and 0 otherwise.
- WAIT:
  - The timeout counter increments each cycle.
  - If acc_done=1, tile_cnt increments. Go to RESP if tile_cnt+1==tiles, otherwise back to RUN with beat=0.
  - If acc_done does not arrive and the counter reaches TIMEOUT-1, go to RESP with rsp_err=1 and rsp_tiles = tiles completed so far.
  - If acc_done and timeout expiry coincide, acc_done wins.
- acc_done while in IDLE, RUN or RESP is ignored; it has no effect on the counters.
- RESP:
  - rsp_valid=1 and rsp_err/rsp_tiles are held stable.
  - When rsp_ready=1, go to IDLE; rsp_valid drops on the next cycle.
  - cmd_ready is 0 while in RESP, so a new command cannot overlap a response.
- Reset asserted mid-job: immediately return to IDLE with all outputs at reset values. An in-flight read response is discarded by the accelerator because valid_mac is 0.

Test Plan:
- Single int8 tile: cmd_base=0x100, tiles=1, mode=01, scale=0x10, bias=0x02; acc_done 5 cycles into WAIT.
  -> opnd_addr 0x100..0x11F over 32 consecutive cycles; valid_mac high for 32 cycles, lagging rd_en by 1; valid_ppu high from RUN through WAIT.
  -> rsp_valid with err=0, tiles=1; is_int8_mode=1, scale=0x10.
- Three int4 tiles: base=0xFF0, tiles=3.
  -> Addresses 0xFF0..0xFFF then wrap to 0x000..0x04F, in three RUN bursts of 32, each separated by a WAIT ended by acc_done.
  -> rsp_tiles=3, err=0.
- Timeout: tiles=2, acc_done for tile 0 only.
  -> In the second WAIT, after 1024 cycles rsp_err=1 and rsp_tiles=1; no further reads.
- Illegal mode 11, tiles=4.
  -> Next cycle RESP with err=1, tiles=0; opnd_rd_en and valid_mac never assert.
- Response backpressure and zero-tile job: tiles=0 with rsp_ready held low 10 cycles.
  -> rsp_valid held for 10 cycles and cmd_ready=0 throughout.
  -> A second command presented meanwhile is accepted only after rsp_ready, in the cycle after returning to IDLE.
- Reset mid-RUN at beat 7.
  -> Outputs zero immediately and cmd_ready=1.
  -> Stray acc_done after reset is ignored; a following job runs normally.
